loop_buffer_slot_sync: RTL and testbench
========================================

Name: loop_buffer_slot_sync

Overview:
Slot-based ping-pong/loop buffer for block-granular data transfer between a producer and a consumer on one clock. The producer writes a block into the current write slot, then commits it with per-block side info or aborts it. The consumer reads committed slots in order at random offsets and releases them. This generation adds exact slot accounting, abort of partial blocks, an almost-full threshold, error flags, read-data valid alignment and held slot info.

Parameters:
DATA_WIDTH, 64, read/write data width
SLOT_AW, 8, address bits within one slot (slot depth = 2**SLOT_AW words)
SLOT_BITS, 2, log2 of slot count (slots = 2**SLOT_BITS)
INFO_WIDTH, 256, per-slot side-info width
READ_LATENCY, 2, rd_en to rd_data cycles (1..4)
AFULL_SLOTS, 1, wr_afull asserts when free_size <= AFULL_SLOTS

Ports:
clk  in  1  clock
syn_rst  in  1  synchronous reset, active high
wr_en  in  1  write data word
wr_addr  in  SLOT_AW  word offset in current write slot
wr_data  in  DATA_WIDTH  write data
wr_commit  in  1  commit current write slot, capture wr_info
wr_abort  in  1  discard current write slot contents
wr_info  in  INFO_WIDTH  side info, sampled on accepted commit
free_size  out  SLOT_BITS+1  number of uncommitted free slots
wr_afull  out  1  free_size <= AFULL_SLOTS
wr_ovf  out  1  sticky: commit attempted while full
rd_vld  out  1  at least one committed slot available
rd_info  out  INFO_WIDTH  info of head slot, stable while rd_vld
rd_en  in  1  read word
rd_addr  in  SLOT_AW  word offset in head slot
rd_data  out  DATA_WIDTH  read data
rd_data_vld  out  1  rd_en delayed READ_LATENCY cycles
rd_release  in  1  free head slot
rd_err  out  1  sticky: release attempted while empty

Behaviour:
- Reset: wbadr=rbadr=0, used count=0, free_size=2**SLOT_BITS, wr_afull=(2**SLOT_BITS<=AFULL_SLOTS), wr_ovf=0, rd_err=0, rd_vld=0, rd_info=0, rd_data_vld pipeline cleared. RAM and info contents are not cleared. Reset mid-block discards all slots; any in-flight rd_data_vld is dropped.
- Write: wr_en writes RAM at {wbadr, wr_addr} with no gating. Writes while full land in the slot at the read head and are the user's fault, so gate on free_size. No write-side flow control beyond free_size.
- Commit accepted when wr_commit and free_size!=0: info_mem[wbadr]<=wr_info, wbadr+1 (wraps mod 2**SLOT_BITS).
- Commit rejected when wr_commit and free_size==0: no state change, wr_ovf<=1 until reset.
- wr_abort: no pointer or count change; the slot is simply rewritten. Commit and abort in the same cycle: abort wins, and that commit is not counted as overflow.
- Release accepted when rd_release and used!=0: rbadr+1 (wraps), used-1.
- Release rejected when rd_release and used==0: ignored, rd_err<=1 until reset.
- Count update: free_size = 2**SLOT_BITS - used, registered. Accepted commit plus accepted release in the same cycle leaves the count unchanged and moves both pointers. A release while full with a simultaneous commit is legal: the release is evaluated against the pre-cycle count and both are accepted.
- rd_vld: registered used!=0; it rises the cycle after commit.
- rd_info: registered from info_mem[rbadr]. It updates the cycle after rbadr changes or the cycle after a commit into an empty buffer, and is held otherwise. rd_info is valid only when rd_vld=1.
- Read: rd_en reads RAM at {rbadr, rd_addr}. rd_data is valid exactly READ_LATENCY cycles later with rd_data_vld=1. Reads issued in the release cycle use the old rbadr.
- wr_afull: combinational compare on registered free_size.

Decomposition:
- Shared package/header: SLOT_NUM=2**SLOT_BITS, TOTAL_AW=SLOT_BITS+SLOT_AW, and a localparam for the free_size reset value.
- One sub-module, loop_slot_ctrl, holds pointers, used/free counter, flags, and commit/release arbitration.
- Top level instantiates loop_slot_ctrl, the team's simple dual-port RAM wrapper (depth 2**TOTAL_AW, output-register stages padded to READ_LATENCY), the info register array, and the rd_en delay line.

Test Plan:
(SLOT_BITS=2, SLOT_AW=4, READ_LATENCY=2, AFULL_SLOTS=1)
- Reset, idle 5 cycles -> free_size=4, rd_vld=0, wr_afull=0, wr_ovf=0, rd_err=0.
- Write words 0..15 = 0xA0+i, commit with info=0x11 -> next cycle free_size=3, rd_vld=1, rd_info=0x11. Read addr 5 -> rd_data=0xA5 with rd_data_vld two cycles after rd_en.
- Commit 4 slots with info 1,2,3,4 -> free_size=0, wr_afull=1. A fifth commit -> wr_ovf=1, free_size stays 0. Release four times -> rd_info sequence 1,2,3,4, free_size returns to 4.
- Full buffer, commit and release in the same cycle -> free_size stays 0, wbadr and rbadr both advance, wr_ovf stays 0, new rd_info = second slot info.
- Write 8 words, assert wr_abort, rewrite 16 words 0xB0+i, commit -> the read slot shows 0xB0..0xBF; free_size dropped by exactly 1.
- rd_release while empty -> rd_err=1, free_size stays 4. Assert syn_rst mid-read with rd_en pulses in flight -> rd_data_vld=0 next cycle, all flags cleared.

Source files
------------

// File: rtl/loop_buffer_slot_sync_pkg.sv
// Shared sizing helpers and default geometry for the slot-based loop buffer.
package loop_buffer_slot_sync_pkg;

  localparam int unsigned DefSlotBits = 2;
  localparam int unsigned DefSlotAw   = 8;

  function automatic int unsigned slot_num(input int unsigned slot_bits);
    return 32'd1 << slot_bits;
  endfunction

  function automatic int unsigned total_aw(input int unsigned slot_bits,
                                           input int unsigned slot_aw);
    return slot_bits + slot_aw;
  endfunction

  // Every slot is free straight out of reset.
  function automatic int unsigned free_size_rst(input int unsigned slot_bits);
    return slot_num(slot_bits);
  endfunction

  localparam int unsigned SLOT_NUM      = slot_num(DefSlotBits);
  localparam int unsigned TOTAL_AW      = total_aw(DefSlotBits, DefSlotAw);
  localparam int unsigned FREE_SIZE_RST = free_size_rst(DefSlotBits);

endpackage

// File: rtl/loop_buffer_slot_sync_ctrl.sv
// Slot pointers, occupancy accounting, sticky error flags and commit/release arbitration.
module loop_slot_ctrl
  import loop_buffer_slot_sync_pkg::*;
#(
  parameter int unsigned SLOT_BITS   = 2,
  parameter int unsigned AFULL_SLOTS = 1
) (
  input  logic                 clk_i,
  input  logic                 syn_rst_i,
  input  logic                 wr_commit_i,
  input  logic                 wr_abort_i,
  input  logic                 rd_release_i,
  output logic                 commit_acc_o,
  output logic                 release_acc_o,
  output logic                 used_empty_o,
  output logic [SLOT_BITS-1:0] wbadr_o,
  output logic [SLOT_BITS-1:0] rbadr_o,
  output logic [SLOT_BITS:0]   free_size_o,
  output logic                 wr_afull_o,
  output logic                 wr_ovf_o,
  output logic                 rd_vld_o,
  output logic                 rd_err_o
);

  localparam logic [SLOT_BITS:0] SlotNumW  = (SLOT_BITS + 1)'(slot_num(SLOT_BITS));
  localparam logic [SLOT_BITS:0] FreeRstW  = (SLOT_BITS + 1)'(free_size_rst(SLOT_BITS));
  localparam logic [SLOT_BITS:0] AfullThrW = (SLOT_BITS + 1)'(AFULL_SLOTS);

  logic [SLOT_BITS-1:0] wbadr_q, wbadr_d;
  logic [SLOT_BITS-1:0] rbadr_q, rbadr_d;
  logic [SLOT_BITS:0]   used_q, used_d;
  logic [SLOT_BITS:0]   free_q, free_d;
  logic                 ovf_q, ovf_d;
  logic                 err_q, err_d;
  logic                 vld_q, vld_d;

  logic commit_req;
  logic commit_acc;
  logic rel_acc;

  always_comb begin
    // Abort overrides a same-cycle commit and the commit is not an overflow.
    commit_req = wr_commit_i & ~wr_abort_i;
    rel_acc    = rd_release_i & (used_q != '0);
    // A release judged on the pre-cycle count frees a slot for a simultaneous commit.
    commit_acc = commit_req & ((free_q != '0) | rel_acc);

    wbadr_d = wbadr_q;
    rbadr_d = rbadr_q;
    used_d  = used_q;
    if (commit_acc) wbadr_d = wbadr_q + 1'b1;
    if (rel_acc)    rbadr_d = rbadr_q + 1'b1;
    if (commit_acc && !rel_acc) begin
      used_d = used_q + 1'b1;
    end else if (!commit_acc && rel_acc) begin
      used_d = used_q - 1'b1;
    end
    free_d = SlotNumW - used_d;
    vld_d  = (used_d != '0);
    ovf_d  = ovf_q | (commit_req & ~commit_acc);
    err_d  = err_q | (rd_release_i & (used_q == '0));
  end

  always_ff @(posedge clk_i) begin
    if (syn_rst_i) begin
      wbadr_q <= '0;
      rbadr_q <= '0;
      used_q  <= '0;
      free_q  <= FreeRstW;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      wbadr_q <= wbadr_d;
      rbadr_q <= rbadr_d;
      used_q  <= used_d;
      free_q  <= free_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  assign commit_acc_o  = commit_acc;
  assign release_acc_o = rel_acc;
  assign used_empty_o  = (used_q == '0);
  assign wbadr_o       = wbadr_q;
  assign rbadr_o       = rbadr_q;
  assign free_size_o   = free_q;
  assign wr_afull_o    = (free_q <= AfullThrW);
  assign wr_ovf_o      = ovf_q;
  assign rd_vld_o      = vld_q;
  assign rd_err_o      = err_q;

endmodule

// File: rtl/loop_buffer_slot_sync.sv
// Slot-based loop buffer: block RAM, per-slot info array, head info register and read pipeline.
module loop_buffer_slot_sync
  import loop_buffer_slot_sync_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned SLOT_AW      = 8,
  parameter int unsigned SLOT_BITS    = 2,
  parameter int unsigned INFO_WIDTH   = 256,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned AFULL_SLOTS  = 1
) (
  input  logic                  clk,
  input  logic                  syn_rst,
  input  logic                  wr_en,
  input  logic [SLOT_AW-1:0]    wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_commit,
  input  logic                  wr_abort,
  input  logic [INFO_WIDTH-1:0] wr_info,
  output logic [SLOT_BITS:0]    free_size,
  output logic                  wr_afull,
  output logic                  wr_ovf,
  output logic                  rd_vld,
  output logic [INFO_WIDTH-1:0] rd_info,
  input  logic                  rd_en,
  input  logic [SLOT_AW-1:0]    rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_vld,
  input  logic                  rd_release,
  output logic                  rd_err
);

  localparam int unsigned TotalAw = total_aw(SLOT_BITS, SLOT_AW);
  localparam int unsigned SlotNum = slot_num(SLOT_BITS);
  localparam int unsigned Depth   = 32'd1 << TotalAw;

  logic                 commit_acc;
  logic                 release_acc;
  logic                 used_empty;
  logic [SLOT_BITS-1:0] wbadr;
  logic [SLOT_BITS-1:0] rbadr;
  logic [SLOT_BITS-1:0] head_next;

  loop_slot_ctrl #(
    .SLOT_BITS   (SLOT_BITS),
    .AFULL_SLOTS (AFULL_SLOTS)
  ) u_ctrl (
    .clk_i         (clk),
    .syn_rst_i     (syn_rst),
    .wr_commit_i   (wr_commit),
    .wr_abort_i    (wr_abort),
    .rd_release_i  (rd_release),
    .commit_acc_o  (commit_acc),
    .release_acc_o (release_acc),
    .used_empty_o  (used_empty),
    .wbadr_o       (wbadr),
    .rbadr_o       (rbadr),
    .free_size_o   (free_size),
    .wr_afull_o    (wr_afull),
    .wr_ovf_o      (wr_ovf),
    .rd_vld_o      (rd_vld),
    .rd_err_o      (rd_err)
  );

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [INFO_WIDTH-1:0] info_mem [SlotNum];
  logic [DATA_WIDTH-1:0] rd_pipe_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0] rd_pipe_d [READ_LATENCY];
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [INFO_WIDTH-1:0] rd_info_q, rd_info_d;

  // Storage is never cleared; occupancy is tracked only by the controller.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wbadr, wr_addr}] <= wr_data;
    if (commit_acc) info_mem[wbadr] <= wr_info;
  end

  always_comb begin
    rd_pipe_d = rd_pipe_q;
    vld_d     = vld_q;
    if (rd_en) rd_pipe_d[0] = mem[{rbadr, rd_addr}];
    vld_d[0] = rd_en;
    for (int i = 1; i < READ_LATENCY; i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
      vld_d[i]     = vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    rd_pipe_q <= rd_pipe_d;
  end

  always_ff @(posedge clk) begin
    if (syn_rst) vld_q <= '0;
    else         vld_q <= vld_d;
  end

  assign head_next = rbadr + 1'b1;

  // Head info is loaded in the same edge that moves the head, bypassing the
  // info array when the new head is being committed in that very cycle.
  always_comb begin
    rd_info_d = rd_info_q;
    if (release_acc) begin
      if (commit_acc && (head_next == wbadr)) rd_info_d = wr_info;
      else                                    rd_info_d = info_mem[head_next];
    end else if (commit_acc && used_empty) begin
      rd_info_d = wr_info;
    end
  end

  always_ff @(posedge clk) begin
    if (syn_rst) rd_info_q <= '0;
    else         rd_info_q <= rd_info_d;
  end

  assign rd_info     = rd_info_q;
  assign rd_data     = rd_pipe_q[READ_LATENCY-1];
  assign rd_data_vld = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_loop_buffer_slot_sync.sv
// Directed bench for loop_buffer_slot_sync with a 4-slot, 16-word, latency-2 configuration.
module tb_loop_buffer_slot_sync;

  localparam int unsigned DW = 64;
  localparam int unsigned SAW = 4;
  localparam int unsigned SB = 2;
  localparam int unsigned IW = 256;
  localparam int unsigned RL = 2;
  localparam int unsigned AF = 1;

  logic           clk;
  logic           syn_rst;
  logic           wr_en;
  logic [SAW-1:0] wr_addr;
  logic [DW-1:0]  wr_data;
  logic           wr_commit;
  logic           wr_abort;
  logic [IW-1:0]  wr_info;
  logic [SB:0]    free_size;
  logic           wr_afull;
  logic           wr_ovf;
  logic           rd_vld;
  logic [IW-1:0]  rd_info;
  logic           rd_en;
  logic [SAW-1:0] rd_addr;
  logic [DW-1:0]  rd_data;
  logic           rd_data_vld;
  logic           rd_release;
  logic           rd_err;

  int checks = 0;
  int errors = 0;

  loop_buffer_slot_sync #(
    .DATA_WIDTH   (DW),
    .SLOT_AW      (SAW),
    .SLOT_BITS    (SB),
    .INFO_WIDTH   (IW),
    .READ_LATENCY (RL),
    .AFULL_SLOTS  (AF)
  ) dut (
    .clk         (clk),
    .syn_rst     (syn_rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_commit   (wr_commit),
    .wr_abort    (wr_abort),
    .wr_info     (wr_info),
    .free_size   (free_size),
    .wr_afull    (wr_afull),
    .wr_ovf      (wr_ovf),
    .rd_vld      (rd_vld),
    .rd_info     (rd_info),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_data_vld (rd_data_vld),
    .rd_release  (rd_release),
    .rd_err      (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_commit = 0; wr_abort = 0; wr_info = '0;
    rd_en = 0; rd_addr = '0; rd_release = 0;
  endtask

  task automatic do_reset();
    syn_rst = 1; tick(); tick(); syn_rst = 0;
  endtask

  task automatic write_slot(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1; wr_addr = SAW'(i); wr_data = DW'(base + 8'(i)); tick();
    end
    wr_en = 0;
  endtask

  task automatic commit(input logic [7:0] info);
    wr_commit = 1; wr_info = IW'(info); tick(); wr_commit = 0;
  endtask

  task automatic test_reset();
    clear_inputs(); do_reset();
    repeat (5) tick();
    checks++; if (free_size !== 3'd4) begin errors++; $display("FAIL reset_free: got %0d want 4", free_size); end
    checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL reset_rd_vld: got %b want 0", rd_vld); end
    checks++; if (wr_afull !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b want 0", wr_afull); end
    checks++; if (wr_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", wr_ovf); end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL reset_rd_err: got %b want 0", rd_err); end
  endtask

  task automatic test_write_read();
    write_slot(8'hA0, 16);
    commit(8'h11);
    checks++; if (free_size !== 3'd3) begin errors++; $display("FAIL wr_free: got %0d want 3", free_size); end
    checks++; if (rd_vld !== 1'b1) begin errors++; $display("FAIL wr_rd_vld: got %b want 1", rd_vld); end
    checks++; if (rd_info !== IW'(8'h11)) begin errors++; $display("FAIL wr_info: got %0h want 11", rd_info); end
    rd_en = 1; rd_addr = 4'd5; tick(); rd_en = 0;
    checks++; if (rd_data_vld !== 1'b0) begin errors++; $display("FAIL rd_early_vld: got %b want 0", rd_data_vld); end
    tick();
    checks++; if (rd_data_vld !== 1'b1) begin errors++; $display("FAIL rd_vld_lat: got %b want 1", rd_data_vld); end
    checks++; if (rd_data !== DW'(8'hA5)) begin errors++; $display("FAIL rd_data5: got %0h want a5", rd_data); end
    tick();
    checks++; if (rd_data_vld !== 1'b0) begin errors++; $display("FAIL rd_vld_drop: got %b want 0", rd_data_vld); end
    rd_release = 1; tick(); rd_release = 0;
    checks++; if (free_size !== 3'd4) begin errors++; $display("FAIL rel_free: got %0d want 4", free_size); end
    checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL rel_rd_vld: got %b want 0", rd_vld); end
  endtask

  task automatic test_fill_ovf();
    for (int i = 1; i <= 3; i++) commit(8'(i));
    checks++; if (wr_afull !== 1'b1) begin errors++; $display("FAIL afull_at1: got %b want 1", wr_afull); end
    commit(8'd4);
    checks++; if (free_size !== 3'd0) begin errors++; $display("FAIL full_free: got %0d want 0", free_size); end
    checks++; if (wr_ovf !== 1'b0) begin errors++; $display("FAIL full_ovf_early: got %b want 0", wr_ovf); end
    commit(8'd5);
    checks++; if (wr_ovf !== 1'b1) begin errors++; $display("FAIL ovf: got %b want 1", wr_ovf); end
    checks++; if (free_size !== 3'd0) begin errors++; $display("FAIL ovf_free: got %0d want 0", free_size); end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (rd_info !== IW'(i)) begin errors++; $display("FAIL fill_info%0d: got %0h want %0h", i, rd_info, i); end
      rd_release = 1; tick(); rd_release = 0;
    end
    checks++; if (free_size !== 3'd4) begin errors++; $display("FAIL drain_free: got %0d want 4", free_size); end
    checks++; if (wr_afull !== 1'b0) begin errors++; $display("FAIL drain_afull: got %b want 0", wr_afull); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) commit(8'h21 + 8'(i));
    checks++; if (rd_info !== IW'(8'h21)) begin errors++; $display("FAIL b2b_head: got %0h want 21", rd_info); end
    wr_commit = 1; wr_info = IW'(8'h25); rd_release = 1; tick();
    wr_commit = 0; rd_release = 0;
    checks++; if (free_size !== 3'd0) begin errors++; $display("FAIL b2b_free: got %0d want 0", free_size); end
    checks++; if (wr_ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", wr_ovf); end
    checks++; if (rd_info !== IW'(8'h22)) begin errors++; $display("FAIL b2b_info: got %0h want 22", rd_info); end
    // Head then walks 0x23, 0x24 and wraps to slot 0, which now holds 0x25.
    for (int i = 0; i < 3; i++) begin
      rd_release = 1; tick(); rd_release = 0;
      checks++;
      if (rd_info !== IW'(8'h23 + 8'(i)))
        begin errors++; $display("FAIL b2b_walk%0d: got %0h want %0h", i, rd_info, 8'h23 + 8'(i)); end
    end
    rd_release = 1; tick(); rd_release = 0;
    checks++; if (free_size !== 3'd4) begin errors++; $display("FAIL b2b_empty: got %0d want 4", free_size); end
  endtask

  task automatic test_abort();
    logic [SAW-1:0] addrs [3];
    addrs[0] = 4'd0; addrs[1] = 4'd3; addrs[2] = 4'd15;
    write_slot(8'hC0, 8);
    wr_abort = 1; wr_commit = 1; wr_info = IW'(8'h99); tick();
    wr_abort = 0; wr_commit = 0;
    checks++; if (free_size !== 3'd4) begin errors++; $display("FAIL abort_free: got %0d want 4", free_size); end
    checks++; if (wr_ovf !== 1'b0) begin errors++; $display("FAIL abort_ovf: got %b want 0", wr_ovf); end
    checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL abort_vld: got %b want 0", rd_vld); end
    write_slot(8'hB0, 16);
    commit(8'h33);
    checks++; if (free_size !== 3'd3) begin errors++; $display("FAIL abort_commit_free: got %0d want 3", free_size); end
    checks++; if (rd_info !== IW'(8'h33)) begin errors++; $display("FAIL abort_info: got %0h want 33", rd_info); end
    for (int k = 0; k < 3; k++) begin
      rd_en = 1; rd_addr = addrs[k]; tick(); rd_en = 0; tick();
      checks++;
      if (rd_data_vld !== 1'b1 || rd_data !== DW'(8'hB0 + 8'(addrs[k])))
        begin errors++; $display("FAIL abort_rd%0d: got %b/%0h want 1/%0h", k, rd_data_vld, rd_data,
                                 8'hB0 + 8'(addrs[k])); end
    end
  endtask

  task automatic test_err_and_reset();
    rd_release = 1; tick(); rd_release = 0;
    checks++; if (free_size !== 3'd4) begin errors++; $display("FAIL err_pre_free: got %0d want 4", free_size); end
    rd_release = 1; tick(); rd_release = 0;
    checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL rd_err: got %b want 1", rd_err); end
    checks++; if (free_size !== 3'd4) begin errors++; $display("FAIL err_free: got %0d want 4", free_size); end
    for (int i = 0; i < 5; i++) commit(8'h40 + 8'(i));
    checks++; if (wr_ovf !== 1'b1) begin errors++; $display("FAIL pre_rst_ovf: got %b want 1", wr_ovf); end
    rd_en = 1; rd_addr = 4'd1; tick();
    syn_rst = 1; tick();
    syn_rst = 0; rd_en = 0;
    checks++; if (rd_data_vld !== 1'b0) begin errors++; $display("FAIL rst_dvld: got %b want 0", rd_data_vld); end
    checks++;
    if (rd_err !== 1'b0 || wr_ovf !== 1'b0 || rd_vld !== 1'b0 || wr_afull !== 1'b0)
      begin errors++; $display("FAIL rst_flags: got err%b ovf%b vld%b afull%b want 0000", rd_err, wr_ovf,
                               rd_vld, wr_afull); end
    checks++; if (free_size !== 3'd4) begin errors++; $display("FAIL rst_free: got %0d want 4", free_size); end
    checks++; if (rd_info !== '0) begin errors++; $display("FAIL rst_info: got %0h want 0", rd_info); end
    tick();
    checks++; if (rd_data_vld !== 1'b0) begin errors++; $display("FAIL rst_dvld2: got %b want 0", rd_data_vld); end
  endtask

  initial begin
    syn_rst = 1;
    clear_inputs();
    test_reset();
    test_write_read();
    test_fill_ovf();
    test_back_to_back();
    test_abort();
    test_err_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
